mem_port_arbiter: RTL

// - Shares the single data-side block-RAM port (dmem port A plus imem write port A) between the CPU

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the data-side RAM port between the CPU memory stage and a loader
// Optional stall performance counter enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic              cpu_sel_imem,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req_valid,
  output logic              ldr_req_ready,
  input  logic [3:0]        ldr_we,
  input  logic              ldr_sel_imem,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_rsp_valid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [3:0]        ram_we_i,
  output logic [3:0]        ram_we_d,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [31:0]       perf_stall_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_CPU, S_LDR} state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [BW-1:0]   burst_cnt;
  logic            cpu_own;
  logic            ldr_accept;
  logic            contention;
  logic [3:0]      own_we;
  logic            own_sel;

  // Reset gates the handshake and enables so nothing leaks out while rst is high.
  assign cpu_own       = ~rst & (state == S_CPU) & cpu_req;
  assign cpu_stall     = ~rst & (state == S_LDR) & cpu_req;
  assign ldr_req_ready = ~rst & ((state == S_LDR) | ~cpu_req);
  assign ldr_accept    = ldr_req_valid & ldr_req_ready;
  assign contention    = ldr_req_valid & cpu_req;

  always_comb begin
    own_we  = 4'h0;
    own_sel = 1'b0;
    if (cpu_own) begin
      own_we  = cpu_we;
      own_sel = cpu_sel_imem;
    end else if (ldr_accept) begin
      own_we  = ldr_we;
      own_sel = ldr_sel_imem;
    end
  end

  assign ram_addr  = cpu_own ? cpu_addr  : ldr_addr;
  assign ram_din   = cpu_own ? cpu_wdata : ldr_wdata;
  assign ram_we_i  = own_we & {4{own_sel}};
  assign ram_we_d  = own_we & {4{~own_sel}};
  assign cpu_rdata = ram_dout;
  assign ldr_rdata = ram_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_CPU;
      starve_cnt    <= '0;
      burst_cnt     <= '0;
      ldr_rsp_valid <= 1'b0;
    end else begin
      ldr_rsp_valid <= ldr_accept & (ldr_we == 4'h0);
      case (state)
        S_CPU: begin
          if (ldr_accept || !ldr_req_valid) begin
            starve_cnt <= '0;
          end else if (contention) begin
            if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
              state      <= S_LDR;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end
        end
        S_LDR: begin
          // Leaving on this edge hands the port straight back to the CPU next cycle.
          if (!ldr_req_valid || burst_cnt == BW'(MAX_BURST - 1)) begin
            state     <= S_CPU;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        default: state <= S_CPU;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (cpu_stall && perf_stall_cnt != 32'hFFFF_FFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
